// File: rtl/sigmoid.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module   : sigmoid                                                         |
// | Purpose  : Multi-cycle float32 logistic activation y = 1/(1+e^-x) using    |
// |            the PLAN piecewise-linear approximation (max abs err ~0.019).   |
// |            Activation stage of each GRU gate.                              |
// | Ports    : clk         - clock, rising edge                                |
// |            rstn        - asynchronous active-low reset                     |
// |            start       - level request, held until done is seen           |
// |            done        - result valid, held while start stays high        |
// |            mult_sum_in - float32 input x, sampled when start accepted     |
// |            neuron_out  - float32 result, held until next completion       |
// | Config   : SIGMOID_SPECIAL_EN - explicit NaN/Inf/zero-exponent handling   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module sigmoid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] mult_sum_in,
  output logic [DATA_WIDTH-1:0] neuron_out
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_UNPACK = 3'd1;
  localparam logic [2:0] c_EVAL   = 3'd2;
  localparam logic [2:0] c_PACK   = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  // Breakpoints in Q4.24, segment offsets and unity in Q1.24
  localparam logic [27:0] c_A_ONE   = 28'h100_0000;  // 1.0
  localparam logic [27:0] c_A_2P375 = 28'h260_0000;  // 2.375
  localparam logic [27:0] c_A_FIVE  = 28'h500_0000;  // 5.0
  localparam logic [24:0] c_Y_ONE   = 25'h100_0000;  // 1.0
  localparam logic [24:0] c_OFS_HI  = 25'h0D8_0000;  // 0.84375
  localparam logic [24:0] c_OFS_MID = 25'h0A0_0000;  // 0.625
  localparam logic [24:0] c_OFS_LO  = 25'h080_0000;  // 0.5

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic [DATA_WIDTH-1:0] r_x;
  logic                  r_s;
  logic                  r_sat;
  logic [27:0]           r_a;
  logic [24:0]           r_y;

  logic [7:0]            w_exp;
  logic [7:0]            w_shamt;
  logic [27:0]           w_a;
  logic [24:0]           w_mag;
  logic [24:0]           w_y;
  logic [4:0]            w_lead;
  logic [22:0]           w_mant;
  logic [31:0]           w_result;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= c_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (start) w_next_state = c_UNPACK;
      c_UNPACK: w_next_state = c_EVAL;
      c_EVAL:   w_next_state = c_PACK;
      c_PACK:   w_next_state = c_DONE;
      c_DONE:   if (!start) w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    done = (r_state == c_DONE);
  end

  // UNPACK: |x| as Q4.24. Mantissa with hidden bit is placed at Q4.24 scale
  // for exp=129 (|x| in [4,8)) and right-shifted for smaller exponents.
  assign w_exp   = r_x[30:23];
  assign w_shamt = 8'd129 - w_exp;
  always_comb begin
    w_a = '0;
    if (w_exp >= 8'd103 && w_exp <= 8'd129)
      w_a = 28'({1'b1, r_x[22:0], 3'b000} >> w_shamt);
  end

  // EVAL: three linear segments plus saturation, mirrored for negative x
  always_comb begin
    if (r_sat || r_a >= c_A_FIVE) w_mag = c_Y_ONE;
    else if (r_a >= c_A_2P375)    w_mag = 25'(r_a >> 5) + c_OFS_HI;
    else if (r_a >= c_A_ONE)      w_mag = 25'(r_a >> 3) + c_OFS_MID;
    else                          w_mag = 25'(r_a >> 2) + c_OFS_LO;
    w_y = r_s ? (c_Y_ONE - w_mag) : w_mag;
  end

  // PACK: leading-one position p gives exponent 103+p (bit 24 is 1.0);
  // bits below the leading one become the truncated mantissa.
  always_comb begin
    w_lead = '0;
    for (int i = 0; i < 25; i++) begin
      if (r_y[i]) w_lead = i[4:0];
    end
    w_mant = 23'({r_y[23:0], 23'b0} >> w_lead);
    if (r_y == '0) w_result = 32'h0000_0000;
    else           w_result = {1'b0, 8'd103 + {3'b000, w_lead}, w_mant};
`ifdef SIGMOID_SPECIAL_EN
    if (w_exp == 8'hFF) begin
      if (r_x[22:0] != '0) w_result = 32'h7FC0_0000;
      else if (r_x[31])    w_result = 32'h0000_0000;
      else                 w_result = 32'h3F80_0000;
    end else if (w_exp == 8'h00) begin
      w_result = 32'h3F00_0000;
    end
`endif
  end

  // Datapath registers; each stage loads only in its own state so the
  // latched operand is immune to input changes after acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x        <= '0;
      r_s        <= 1'b0;
      r_sat      <= 1'b0;
      r_a        <= '0;
      r_y        <= '0;
      neuron_out <= '0;
    end else begin
      case (r_state)
        c_IDLE:   if (start) r_x <= mult_sum_in;
        c_UNPACK: begin
          r_s   <= r_x[31];
          r_sat <= (w_exp >= 8'd130);
          r_a   <= w_a;
        end
        c_EVAL:   r_y <= w_y;
        c_PACK:   neuron_out <= w_result;
        default:  ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sigmoid.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module   : tb_sigmoid                                                      |
// | Purpose  : Directed self-checking bench for sigmoid: reset state, curve    |
// |            segments, saturation, handshake, early start drop and          |
// |            asynchronous abort.                                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_sigmoid;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        done;
  logic [31:0] mult_sum_in;
  logic [31:0] neuron_out;

  int checks   = 0;
  int failures = 0;

  sigmoid #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .done        (done),
    .mult_sum_in (mult_sum_in),
    .neuron_out  (neuron_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction: done must be low after 3 edges, high after the 4th,
  // and clear one edge after start falls.
  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] exp);
    mult_sum_in = x;
    start       = 1'b1;
    tick(); tick(); tick();
    check({tag, "_early"}, {31'b0, done}, 32'd0);
    tick();
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check(tag, neuron_out, exp);
    start = 1'b0;
    tick();
    check({tag, "_clr"}, {31'b0, done}, 32'd0);
  endtask

  logic [31:0] nan_exp;

  initial begin
    rstn        = 1'b0;
    start       = 1'b0;
    mult_sum_in = 32'h0;
    tick(); tick();
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_out", neuron_out, 32'h0);
    rstn = 1'b1;
    tick();

    run("zero",   32'h0000_0000, 32'h3F00_0000);
    run("p1",     32'h3F80_0000, 32'h3F40_0000);
    run("m1",     32'hBF80_0000, 32'h3E80_0000);
    run("p2",     32'h4000_0000, 32'h3F60_0000);
    run("p0p5",   32'h3F00_0000, 32'h3F20_0000);
    run("p3",     32'h4040_0000, 32'h3F70_0000);
    run("m3",     32'hC040_0000, 32'h3D80_0000);
    run("p6",     32'h40C0_0000, 32'h3F80_0000);
    run("m6",     32'hC0C0_0000, 32'h0000_0000);
    run("p5",     32'h40A0_0000, 32'h3F80_0000);   // knee into saturation
    run("p2p375", 32'h4018_0000, 32'h3F6B_0000);   // 235/256
    run("p0p25",  32'h3E80_0000, 32'h3F10_0000);   // 0.5625
    run("m0p5",   32'hBF00_0000, 32'h3EC0_0000);   // 0.375
    run("m2",     32'hC000_0000, 32'h3E00_0000);   // 0.125
    run("p100",   32'h42C8_0000, 32'h3F80_0000);   // exp >= 130
    run("tiny",   32'h2EDB_E6FF, 32'h3F00_0000);   // exp <= 102
    run("minf",   32'hFF80_0000, 32'h0000_0000);
`ifdef SIGMOID_SPECIAL_EN
    nan_exp = 32'h7FC0_0000;
`else
    nan_exp = 32'h3F80_0000;
`endif
    run("nan",    32'h7FC0_0000, nan_exp);

    // done holds while start stays high
    mult_sum_in = 32'h3F80_0000;
    start       = 1'b1;
    tick(); tick(); tick(); tick();
    tick(); tick(); tick();
    check("hold_done", {31'b0, done}, 32'd1);
    check("hold_out", neuron_out, 32'h3F40_0000);
    start = 1'b0;
    tick();
    check("hold_clr", {31'b0, done}, 32'd0);

    // start dropped after acceptance; later input change must be ignored
    mult_sum_in = 32'h4040_0000;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    mult_sum_in = 32'hC0C0_0000;
    tick(); tick();
    check("drop_early", {31'b0, done}, 32'd0);
    tick();
    check("drop_done", {31'b0, done}, 32'd1);
    check("drop_out", neuron_out, 32'h3F70_0000);
    tick();
    check("drop_pulse", {31'b0, done}, 32'd0);

    // asynchronous reset during EVAL aborts immediately
    mult_sum_in = 32'h3F80_0000;
    start       = 1'b1;
    tick(); tick();
    rstn = 1'b0;
    #1;
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_out", neuron_out, 32'h0);
    start = 1'b0;
    tick();
    #2;
    rstn = 1'b1;
    tick();
    check("abort_idle", {31'b0, done}, 32'd0);
    run("recover", 32'hBF80_0000, 32'h3E80_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
